instqueue_dual: RTL
===================

# instqueue_dual

Two-wide, parametrised instruction queue between the fetch unit and the decoder. Accepts up to two (instruction, pc) pairs per cycle from fetch and retires up to two per cycle to decode, presenting the two oldest entries as registered outputs with valid flags. Extends the single-port queue with configurable depth and width, dual push/pop, an occupancy count and an almost-full threshold. It also adds a same-cycle bypass so that a push into an empty queue is visible on the next edge.

## Interface

Parameters:
- DATA_W, 32, instruction word width
- PC_W, 32, pc width
- DEPTH_LOG, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG, minimum 2
- AFULL_TH, 4, afull_o asserts when free entries ≤ AFULL_TH

Ports:
- clk  in  1  single clock; all state changes on posedge clk
- rst  in  1  asynchronous, active-high reset
- rst_c  in  1  synchronous flush (branch mispredict); takes effect even when rdy=0
- rdy  in  1  global ready; when 0, all state and outputs hold
- wr_cnt_i  in  2  entries offered this cycle: 0, 1 or 2; value 3 treated as 2
- inst0_i, inst1_i  in  DATA_W  offered instructions, slot 0 older
- pc0_i, pc1_i  in  PC_W  matching pcs
- rd_cnt_i  in  2  entries consumed this cycle: 0, 1 or 2; value 3 treated as 2
- inst0_o, inst1_o  out  DATA_W  oldest and second-oldest entries
- pc0_o, pc1_o  out  PC_W  matching pcs
- valid0_o, valid1_o  out  1  entry 0 / entry 1 present
- count_o  out  DEPTH_LOG+1  occupancy
- full_o  out  1  free entries < 2, so a double push cannot be guaranteed
- afull_o  out  1  free entries ≤ AFULL_TH
- empty_o  out  1  count = 0
- wr_acc_o  out  2  combinational: entries actually accepted this cycle

## Operation

- Storage is a circular buffer of DEPTH entries with DEPTH_LOG-bit head and tail pointers. Pointers wrap modulo DEPTH. count is held separately, DEPTH_LOG+1 bits.
- Each cycle with rdy=1 and no flush:
  - rd_acc = min(rd_cnt, count). Consuming beyond occupancy is clamped, never underflows.
  - free_eff = DEPTH − count + rd_acc. Pops free space for same-cycle pushes.
  - wr_acc = min(wr_cnt, free_eff). Slot 0 is accepted before slot 1, and only a prefix is accepted.
  - Accepted entries are written at tail, tail+1.
  - head += rd_acc; tail += wr_acc; count_n = count − rd_acc + wr_acc.
- Registered outputs reflect post-update state. inst0_o/pc0_o = entry at head_n; inst1_o/pc1_o = entry at head_n+1.
  - valid0_o = count_n ≥ 1; valid1_o = count_n ≥ 2.
  - If either position is being written this cycle, the incoming data is forwarded (bypass).
  - Data outputs with valid=0 are don't-care but must not be X after reset.
- Flag derivation: full_o = (DEPTH − count_n) < 2; afull_o = (DEPTH − count_n) ≤ AFULL_TH; empty_o = (count_n = 0).
- rst_c: head, tail and count go to 0, valids go to 0, empty_o=1, full_o=0, afull_o=0. Data outputs hold. Incoming writes that cycle are discarded.
- rdy=0 with no flush: no push, no pop; wr_acc_o = 0.

## Timing

- Reset values (rst asserted, asynchronous): head=tail=count=0, valid0_o=valid1_o=0, empty_o=1, full_o=0, afull_o=0, count_o=0, inst*/pc* outputs=0.
- Priority: rst > rst_c > rdy.
- Push-to-visible latency: 1 cycle. Data pushed into an empty queue at edge N appears on inst0_o with valid0_o=1 after edge N.
- Simultaneous pop 2 and push 2 with count=DEPTH: both are accepted; count stays DEPTH.
- Wrap-around: pushing 2 with tail=DEPTH−1 writes entries DEPTH−1 and 0.
- Flags, count_o and outputs are consistent with each other in every cycle; all are registered.
- wr_acc_o is the only combinational output. It depends on the current count, rd_cnt_i, wr_cnt_i, rdy and rst_c.

## Test plan

- Reset then push 2 (inst 0xA0/0xA1, pc 0x0/0x4) → next cycle inst0_o=0xA0, inst1_o=0xA1, valid0_o=valid1_o=1, count_o=2, empty_o=0.
- DEPTH_LOG=4: fill with 8 double pushes, no pops → count_o=16, full_o=1; further push 2 → wr_acc_o=0, contents unchanged. Then pop 2 and push 2 in the same cycle → wr_acc_o=2, count_o stays 16.
- count=15, push 2, no pop → wr_acc_o=1, only slot 0 stored, count_o=16. Pop ordering preserves FIFO order across the pointer wrap at entry 15→0.
- count=1, rd_cnt_i=2 → rd_acc clamps to 1, count_o=0, empty_o=1, valid0_o=0, no underflow.
- rdy=0 for 3 cycles with push/pop requested → all outputs frozen. rst_c pulsed with rdy=0 and push 2 → count_o=0, empty_o=1 next cycle, pushed data discarded.
- Assert rst mid-cycle with count=5 → outputs reach reset values without waiting for a clock edge. After release, the first push behaves as from an empty queue.
- AFULL_TH=4: fill to count 12 → afull_o=1, full_o=0; at count 11 → afull_o=0.

Source files
------------

// File: rtl/instqueue_dual.sv
// instqueue_dual: two-wide fetch-to-decode instruction queue with registered head view and write bypass
module instqueue_dual #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int DEPTH_LOG = 4,
  parameter int AFULL_TH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rst_c,
  input  logic                 rdy,
  input  logic [1:0]           wr_cnt_i,
  input  logic [DATA_W-1:0]    inst0_i,
  input  logic [DATA_W-1:0]    inst1_i,
  input  logic [PC_W-1:0]      pc0_i,
  input  logic [PC_W-1:0]      pc1_i,
  input  logic [1:0]           rd_cnt_i,
  output logic [DATA_W-1:0]    inst0_o,
  output logic [DATA_W-1:0]    inst1_o,
  output logic [PC_W-1:0]      pc0_o,
  output logic [PC_W-1:0]      pc1_o,
  output logic                 valid0_o,
  output logic                 valid1_o,
  output logic [DEPTH_LOG:0]   count_o,
  output logic                 full_o,
  output logic                 afull_o,
  output logic                 empty_o,
  output logic [1:0]           wr_acc_o
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int CW    = DEPTH_LOG + 1;
  localparam int EW    = DATA_W + PC_W;
  typedef logic [DEPTH_LOG-1:0] ptr_t;
  logic [EW-1:0] mem_q [DEPTH];
  ptr_t head_q, tail_q, head_d, tail_d, tail1, head1_d;
  logic [CW-1:0] count_q, count_d, free_d;
  logic [CW:0] free_eff;
  logic [1:0] wr_req, rd_req, rd_acc, wr_acc;
  logic [EW-1:0] in0, in1, e0_d, e1_d;
  logic go;
  logic [DATA_W-1:0] inst0_q, inst1_q;
  logic [PC_W-1:0] pc0_q, pc1_q;
  logic valid0_q, valid1_q, full_q, afull_q, empty_q;
  always_comb begin
    go       = rdy & ~rst_c;
    wr_req   = (wr_cnt_i == 2'd3) ? 2'd2 : wr_cnt_i;
    rd_req   = (rd_cnt_i == 2'd3) ? 2'd2 : rd_cnt_i;
    rd_acc   = !go ? 2'd0 : (CW'(rd_req) > count_q) ? count_q[1:0] : rd_req;
    free_eff = (CW+1)'(DEPTH) - (CW+1)'(count_q) + (CW+1)'(rd_acc);
    wr_acc   = !go ? 2'd0 : ((CW+1)'(wr_req) > free_eff) ? free_eff[1:0] : wr_req;
    head_d   = head_q + ptr_t'(rd_acc);
    tail_d   = tail_q + ptr_t'(wr_acc);
    tail1    = tail_q + ptr_t'(1);
    head1_d  = head_d + ptr_t'(1);
    count_d  = count_q - CW'(rd_acc) + CW'(wr_acc);
    free_d   = CW'(DEPTH) - count_d;
    in0      = {inst0_i, pc0_i};
    in1      = {inst1_i, pc1_i};
    // head view after this cycle's writes land, so a push into an empty queue shows next edge
    e0_d = (wr_acc != 2'd0 && head_d == tail_q) ? in0 :
           (wr_acc == 2'd2 && head_d == tail1) ? in1 : mem_q[head_d];
    e1_d = (wr_acc != 2'd0 && head1_d == tail_q) ? in0 :
           (wr_acc == 2'd2 && head1_d == tail1) ? in1 : mem_q[head1_d];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      inst0_q  <= '0;
      inst1_q  <= '0;
      pc0_q    <= '0;
      pc1_q    <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
    end else if (rst_c) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
    end else if (rdy) begin
      if (wr_acc != 2'd0) mem_q[tail_q] <= in0;
      if (wr_acc == 2'd2) mem_q[tail1] <= in1;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      {inst0_q, pc0_q} <= e0_d;
      {inst1_q, pc1_q} <= e1_d;
      valid0_q <= count_d != '0;
      valid1_q <= count_d >= CW'(2);
      empty_q  <= count_d == '0;
      full_q   <= free_d < CW'(2);
      afull_q  <= int'(free_d) <= AFULL_TH;
    end
  end
  assign inst0_o  = inst0_q;
  assign inst1_o  = inst1_q;
  assign pc0_o    = pc0_q;
  assign pc1_o    = pc1_q;
  assign valid0_o = valid0_q;
  assign valid1_o = valid1_q;
  assign count_o  = count_q;
  assign full_o   = full_q;
  assign afull_o  = afull_q;
  assign empty_o  = empty_q;
  assign wr_acc_o = wr_acc;
endmodule
